// File: rtl/pc_fetch_reg_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_reg_pkg
//   Shared memory-map constants, fetch state encoding and an address-range
//   helper for the IF-stage program-counter register and the address checkers.
// ---------------------------------------------------------------------------
package pc_fetch_reg_pkg;

  // Memory map: user text and kernel text segments.
  localparam logic [31:0] TEXT_STARTADDR  = 32'h0000_3000;
  localparam logic [31:0] KTEXT_STARTADDR = 32'h0000_4180;

  localparam logic [31:0] TEXT_LO_ADDR  = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI_ADDR  = 32'h0000_6FFC;
  localparam logic [31:0] KTEXT_LO_ADDR = 32'h0000_4180;
  localparam logic [31:0] KTEXT_HI_ADDR = 32'h0000_4FFC;

  // The word just below the kernel text acts as the end-of-program sentinel.
  localparam logic [31:0] HALT_ADDR = KTEXT_STARTADDR - 32'd4;

  // Fetch state encoding.
  typedef enum logic [1:0] {
    PCS_RUN   = 2'd0,
    PCS_STALL = 2'd1,
    PCS_HALT  = 2'd2
  } pc_state_e;

  // Inclusive unsigned range test.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/pc_fetch_reg_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_reg_if
//   Bundles the hazard / next-PC inputs and the fetch-address outputs of the
//   PC register.
//   master : hazard unit, next-PC selector and CP0 side (drives control, NPC)
//   slave  : pc_fetch_reg (drives PC, BD, excAdEL, halted, fetchCount)
// ---------------------------------------------------------------------------
interface pc_fetch_reg_if;
  logic        stall;
  logic        redirect;
  logic [31:0] NPC;
  logic        curIsJump;
  logic [31:0] PC;
  logic        BD;
  logic        excAdEL;
  logic        halted;
  logic [31:0] fetchCount;

  modport master (
    output stall, redirect, NPC, curIsJump,
    input  PC, BD, excAdEL, halted, fetchCount
  );

  modport slave (
    input  stall, redirect, NPC, curIsJump,
    output PC, BD, excAdEL, halted, fetchCount
  );
endinterface

// File: rtl/pc_fetch_reg_range_check.sv
// ---------------------------------------------------------------------------
// pc_fetch_reg_range_check
//   Combinational fetch/load address checker: flags a word address that is
//   misaligned or lies outside both the user and kernel text windows.
//   Ports:
//     addr  in  32  address to check
//     fault out 1   1 = misaligned or out of both windows
// ---------------------------------------------------------------------------
module pc_fetch_reg_range_check
  import pc_fetch_reg_pkg::*;
#(
  parameter logic [31:0] TEXT_LO  = TEXT_LO_ADDR,
  parameter logic [31:0] TEXT_HI  = TEXT_HI_ADDR,
  parameter logic [31:0] KTEXT_LO = KTEXT_LO_ADDR,
  parameter logic [31:0] KTEXT_HI = KTEXT_HI_ADDR
) (
  input  logic [31:0] addr,
  output logic        fault
);

  logic misaligned_s;
  logic in_window_s;

  // Alignment and window decode.
  always_comb begin
    misaligned_s = (addr[1:0] != 2'b00);
    in_window_s  = addr_in_range(addr, TEXT_LO, TEXT_HI) ||
                   addr_in_range(addr, KTEXT_LO, KTEXT_HI);
    fault        = misaligned_s || !in_window_s;
  end

endmodule

// File: rtl/pc_fetch_reg.sv
// ---------------------------------------------------------------------------
// pc_fetch_reg
//   IF-stage program counter. Each cycle it loads NPC, holds on a stall, or
//   takes a CP0 redirect that overrides the stall. Tracks the delay-slot flag
//   of the fetched instruction, flags fetch address errors, counts PC
//   advances, and parks in HALT once the end sentinel is loaded.
//   Ports:
//     clk         in   1   clock, rising edge
//     reset       in   1   synchronous active-high reset, highest priority
//     bus         slave modport of pc_fetch_reg_if:
//       stall, redirect, NPC, curIsJump  in
//       PC, BD, excAdEL, halted, fetchCount out
// ---------------------------------------------------------------------------
module pc_fetch_reg
  import pc_fetch_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = TEXT_STARTADDR,
  parameter logic [31:0] HALT_PC  = HALT_ADDR,
  parameter logic [31:0] TEXT_LO  = TEXT_LO_ADDR,
  parameter logic [31:0] TEXT_HI  = TEXT_HI_ADDR,
  parameter logic [31:0] KTEXT_LO = KTEXT_LO_ADDR,
  parameter logic [31:0] KTEXT_HI = KTEXT_HI_ADDR
) (
  input  logic          clk,
  input  logic          reset,
  pc_fetch_reg_if.slave bus
);

  pc_state_e   state_r;
  pc_state_e   state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_s;
  logic        bd_r;
  logic        bd_s;
  logic [31:0] cnt_r;
  logic [31:0] cnt_s;
  logic        advance_s;
  logic        fault_s;

  // Next-state, next-PC, delay-slot and counter decode.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    bd_s      = bd_r;
    cnt_s     = cnt_r;
    advance_s = 1'b0;

    case (state_r)
      PCS_RUN, PCS_STALL: begin
        if (bus.redirect) begin
          // Handler entry and ERET targets never sit in a delay slot.
          advance_s = 1'b1;
          bd_s      = 1'b0;
          state_s   = PCS_RUN;
        end else if (bus.stall) begin
          state_s   = PCS_STALL;
        end else begin
          advance_s = 1'b1;
          bd_s      = bus.curIsJump;
          state_s   = PCS_RUN;
        end
      end
      PCS_HALT: begin
        state_s = PCS_HALT;
      end
      default: begin
        // Unreachable encoding: hold the datapath and resume normal fetch.
        state_s = PCS_RUN;
      end
    endcase

    if (advance_s) begin
      pc_s  = bus.NPC;
      cnt_s = cnt_r + 32'd1;
      // Loading the sentinel halts on the same edge, overriding RUN/STALL.
      if (bus.NPC == HALT_PC) begin
        state_s = PCS_HALT;
      end else begin
        state_s = state_s;
      end
    end else begin
      pc_s = pc_s;
    end
  end

  // State, PC, delay-slot flag and advance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= PCS_RUN;
      pc_r    <= RESET_PC;
      bd_r    <= 1'b0;
      cnt_r   <= 32'd0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      bd_r    <= bd_s;
      cnt_r   <= cnt_s;
    end
  end

  pc_fetch_reg_range_check #(
    .TEXT_LO  (TEXT_LO),
    .TEXT_HI  (TEXT_HI),
    .KTEXT_LO (KTEXT_LO),
    .KTEXT_HI (KTEXT_HI)
  ) u_range_check (
    .addr  (pc_r),
    .fault (fault_s)
  );

  // Output mapping; the address error is suppressed once fetch is parked.
  always_comb begin
    bus.PC         = pc_r;
    bus.BD         = bd_r;
    bus.fetchCount = cnt_r;
    bus.halted     = (state_r == PCS_HALT);
    if (state_r == PCS_HALT) begin
      bus.excAdEL = 1'b0;
    end else begin
      bus.excAdEL = fault_s;
    end
  end

endmodule

// File: tb/tb_pc_fetch_reg.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_reg
//   Directed vector table for the documented scenarios, then randomized
//   traffic compared against a behavioural model of the PC register.
// ---------------------------------------------------------------------------
module tb_pc_fetch_reg;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] npc;
    logic        cur;
    logic [31:0] exp_pc;
    logic        exp_bd;
    logic [31:0] exp_cnt;
    logic        exp_halt;
    logic        exp_adel;
  } vec_t;

  localparam logic [31:0] M_HALT = 32'h0000_417C;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  // Model state
  logic [31:0] m_pc;
  logic        m_bd;
  logic [31:0] m_cnt;
  logic        m_halt;

  pc_fetch_reg_if bus ();

  pc_fetch_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic st, input logic rd,
                     input logic [31:0] npc, input logic cur,
                     input logic [31:0] epc, input logic ebd,
                     input logic [31:0] ecnt, input logic eh, input logic ea);
    vec_t v;
    v.rst = rst; v.stall = st; v.redirect = rd; v.npc = npc; v.cur = cur;
    v.exp_pc = epc; v.exp_bd = ebd; v.exp_cnt = ecnt; v.exp_halt = eh; v.exp_adel = ea;
    vecs.push_back(v);
  endtask

  function automatic logic ref_adel(input logic [31:0] pc, input logic halted);
    logic in_text;
    logic in_ktext;
    in_text  = (pc >= 32'h3000) && (pc <= 32'h6FFC);
    in_ktext = (pc >= 32'h4180) && (pc <= 32'h4FFC);
    if (halted) return 1'b0;
    return ((pc % 32'd4) != 32'd0) || !(in_text || in_ktext);
  endfunction

  // Behavioural rule set: halted freezes; redirect beats stall; stall holds.
  task automatic model_step(input logic rst, input logic st, input logic rd,
                            input logic [31:0] npc, input logic cur);
    if (rst) begin
      m_pc = 32'h3000; m_bd = 1'b0; m_cnt = 32'd0; m_halt = 1'b0;
    end else if (!m_halt && (rd || !st)) begin
      m_pc  = npc;
      m_bd  = rd ? 1'b0 : cur;
      m_cnt = m_cnt + 32'd1;
      if (npc == M_HALT) m_halt = 1'b1;
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic rd,
                       input logic [31:0] npc, input logic cur);
    reset         = rst;
    bus.stall     = st;
    bus.redirect  = rd;
    bus.NPC       = npc;
    bus.curIsJump = cur;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    //   rst   st    rd    npc           cur   pc            bd    cnt    h     adel
    add(1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_3000, 1'b0, 32'd0,  1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0000_3004, 1'b0, 32'h0000_3004, 1'b0, 32'd1,  1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0000_3008, 1'b0, 32'h0000_3008, 1'b0, 32'd2,  1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0000_3010, 1'b1, 32'h0000_3008, 1'b0, 32'd2,  1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0000_3010, 1'b1, 32'h0000_3008, 1'b0, 32'd2,  1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0000_300C, 1'b0, 32'h0000_300C, 1'b0, 32'd3,  1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 32'h0000_4180, 1'b1, 32'h0000_4180, 1'b0, 32'd4,  1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0000_3010, 1'b0, 32'h0000_3010, 1'b0, 32'd5,  1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0000_3014, 1'b1, 32'h0000_3014, 1'b1, 32'd6,  1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0000_3018, 1'b0, 32'h0000_3018, 1'b0, 32'd7,  1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 32'h0000_3020, 1'b1, 32'h0000_3020, 1'b0, 32'd8,  1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0000_3002, 1'b0, 32'h0000_3002, 1'b0, 32'd9,  1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0000_2FFC, 1'b0, 32'h0000_2FFC, 1'b0, 32'd10, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0000_4180, 1'b0, 32'h0000_4180, 1'b0, 32'd11, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0000_7000, 1'b0, 32'h0000_7000, 1'b0, 32'd12, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0000_6FFC, 1'b0, 32'h0000_6FFC, 1'b0, 32'd13, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0000_417C, 1'b0, 32'h0000_417C, 1'b0, 32'd14, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_417C, 1'b0, 32'd14, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 32'h0000_5000, 1'b1, 32'h0000_417C, 1'b0, 32'd14, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0000_3002, 1'b0, 32'h0000_417C, 1'b0, 32'd14, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 32'h0000_5000, 1'b1, 32'h0000_3000, 1'b0, 32'd0,  1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0000_3004, 1'b0, 32'h0000_3000, 1'b0, 32'd0,  1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 32'h0000_417C, 1'b1, 32'h0000_417C, 1'b0, 32'd1,  1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0000_3004, 1'b0, 32'h0000_3000, 1'b0, 32'd0,  1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].npc, vecs[i].cur);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pc", i),     bus.PC,               vecs[i].exp_pc);
      chk($sformatf("vec%0d_bd", i),     {31'd0, bus.BD},      {31'd0, vecs[i].exp_bd});
      chk($sformatf("vec%0d_cnt", i),    bus.fetchCount,       vecs[i].exp_cnt);
      chk($sformatf("vec%0d_halted", i), {31'd0, bus.halted},  {31'd0, vecs[i].exp_halt});
      chk($sformatf("vec%0d_adel", i),   {31'd0, bus.excAdEL}, {31'd0, vecs[i].exp_adel});
    end

    // Randomized phase, starting from a fresh reset.
    model_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 3000; c++) begin
      logic        r_rst;
      logic        r_st;
      logic        r_rd;
      logic        r_cur;
      logic [31:0] r_npc;
      int          sel;
      r_rst = ($urandom_range(0, 99) < 2);
      r_st  = ($urandom_range(0, 99) < 30);
      r_rd  = ($urandom_range(0, 99) < 10);
      r_cur = $urandom_range(0, 1) == 1;
      sel   = $urandom_range(0, 99);
      if (sel < 65)      r_npc = m_pc + 32'd4;
      else if (sel < 80) r_npc = 32'h3000 + (32'($urandom_range(0, 4095)) * 32'd4);
      else if (sel < 88) r_npc = $urandom;
      else if (sel < 96) r_npc = m_pc + 32'd2;
      else               r_npc = M_HALT;
      drive(r_rst, r_st, r_rd, r_npc, r_cur);
      model_step(r_rst, r_st, r_rd, r_npc, r_cur);
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_pc", c),     bus.PC,               m_pc);
      chk($sformatf("rnd%0d_bd", c),     {31'd0, bus.BD},      {31'd0, m_bd});
      chk($sformatf("rnd%0d_cnt", c),    bus.fetchCount,       m_cnt);
      chk($sformatf("rnd%0d_halted", c), {31'd0, bus.halted},  {31'd0, m_halt});
      chk($sformatf("rnd%0d_adel", c),   {31'd0, bus.excAdEL}, {31'd0, ref_adel(m_pc, m_halt)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
